// File: rtl/spi_slave_mem.sv
// SPI slave with a DEPTH x 32 register memory: 64-bit frames {cmd, addr, data}, MSB first.
// Command 0x00 writes data to mem[addr]; any other command returns mem[addr] on miso in the data phase.
module spi_slave_mem #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cs,
   input  logic        sck,
   input  logic        mosi,
   output logic        miso,
   output logic        frame_done,
   output logic        frame_abort,
   output logic [7:0]  frame_cmd,
   output logic [23:0] frame_addr
);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;

   state_t state, state_nx;

   logic [1:0] cs_s, sck_s, mosi_s;
   logic       cs_d, sck_d;
   logic       cs_q, sck_q, mosi_q;
   logic       cs_fall, sck_rise, sck_fall;
   logic       bit_in, end_cmd, end_addr, commit, abort;

   logic [6:0]  bit_cnt;
   logic [31:0] rx_sr, rx_next;
   logic [7:0]  cmd;
   logic [23:0] addr;
   logic [31:0] rd_shift;
   logic [DEPTH-1:0][31:0] mem;

   // cs sync flops clear to 0 so a cs held low through reset is not seen as a new falling edge
   always_ff @(posedge clk) begin
      if (rst) begin
         cs_s   <= 2'b00;
         cs_d   <= 1'b0;
         sck_s  <= 2'b11;
         sck_d  <= 1'b1;
         mosi_s <= 2'b00;
      end else begin
         cs_s   <= {cs_s[0], cs};
         cs_d   <= cs_s[1];
         sck_s  <= {sck_s[0], sck};
         sck_d  <= sck_s[1];
         mosi_s <= {mosi_s[0], mosi};
      end
   end

   assign cs_q     = cs_s[1];
   assign sck_q    = sck_s[1];
   assign mosi_q   = mosi_s[1];
   assign cs_fall  = cs_d & ~cs_q;
   assign sck_rise = sck_q & ~sck_d;
   assign sck_fall = ~sck_q & sck_d;

   // A rise is taken even when cs rises in the same cycle, so bit 64 still completes the frame
   assign bit_in   = sck_rise & (state == CMD || state == ADDR || state == DATA);
   assign end_cmd  = bit_in & (state == CMD)  & (bit_cnt == 7'd7);
   assign end_addr = bit_in & (state == ADDR) & (bit_cnt == 7'd31);
   assign commit   = bit_in & (state == DATA) & (bit_cnt == 7'd63);
   assign rx_next  = {rx_sr[30:0], mosi_q};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      abort    = 1'b0;
      case (state)
         IDLE: if (cs_fall) state_nx = CMD;
         CMD: begin
            if (cs_q) begin
               state_nx = IDLE;
               abort    = 1'b1;
            end else if (end_cmd) begin
               state_nx = ADDR;
            end
         end
         ADDR: begin
            if (cs_q) begin
               state_nx = IDLE;
               abort    = 1'b1;
            end else if (end_addr) begin
               state_nx = DATA;
            end
         end
         DATA: begin
            if (commit) begin
               state_nx = cs_q ? IDLE : DONE;
            end else if (cs_q) begin
               state_nx = IDLE;
               abort    = 1'b1;
            end
         end
         DONE: if (cs_q) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt     <= '0;
         rx_sr       <= '0;
         cmd         <= '0;
         addr        <= '0;
         rd_shift    <= '0;
         miso        <= 1'b0;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
         frame_cmd   <= '0;
         frame_addr  <= '0;
         mem         <= '0;
      end else begin
         frame_done  <= commit;
         frame_abort <= abort;

         if (cs_q)        bit_cnt <= '0;
         else if (bit_in) bit_cnt <= bit_cnt + 7'd1;

         if (bit_in)  rx_sr <= rx_next;
         if (end_cmd) cmd   <= rx_next[7:0];

         // Fetch uses the address being completed this cycle so read data is ready on entry to DATA
         if (end_addr) begin
            addr     <= rx_next[23:0];
            rd_shift <= (cmd != 8'h00) ? mem[rx_next[AW-1:0]] : 32'h0;
         end

         if (state == DATA) begin
            if (sck_fall) begin
               miso     <= rd_shift[31];
               rd_shift <= {rd_shift[30:0], 1'b0};
            end
         end else begin
            miso <= 1'b0;
         end

         if (commit) begin
            if (cmd == 8'h00) mem[addr[AW-1:0]] <= rx_next;
            frame_cmd  <= cmd;
            frame_addr <= addr;
         end
      end
   end

endmodule

// File: doc/spi_slave_mem.md
# spi_slave_mem

SPI slave endpoint that sits directly downstream of the SPI master on the MOSI/MISO/SCK/CS link. It deserialises 64-bit frames, each made of an 8-bit command, a 24-bit address and a 32-bit data word, MSB first. It executes the frame against an internal 32-bit register memory: command 0x00 is a write, and any other command is a read. Read data is returned serially on MISO during the data phase of the same frame.

## Interface
- DEPTH, 16: number of 32-bit memory words; power of two, 2..256.
- AW, log2(DEPTH): address bits used; address bits [23:AW] are ignored, so addresses wrap.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high. Reset rst, synchronous, active-high; clock clk.
- cs  in  1  chip select, active-low; asynchronous to clk.
- sck  in  1  serial clock, idles high; asynchronous to clk.
- mosi  in  1  serial data from master.
- miso  out  1  serial data to master; driven 0 whenever not in a read data phase.
- frame_done  out  1  one-cycle pulse when a complete 64-bit frame has been executed.
- frame_abort  out  1  one-cycle pulse when cs rises before bit 64.
- frame_cmd  out  8  command of the last completed frame.
- frame_addr  out  24  address of the last completed frame.

## Operation
- Synchronisation:
  - cs, sck and mosi each pass through a 2-flop synchroniser.
  - sck rising and falling edges are detected from the synchronised sck and its delayed copy.
- Bit protocol:
  - Bits are sampled from mosi on each detected sck rising edge while cs is low.
  - miso is updated on each detected sck falling edge.
- Bit counter: 7-bit counter holding 0..64; it is cleared whenever cs is high.
- FSM states are IDLE, CMD, ADDR, DATA and DONE.
  - IDLE → CMD: synchronised cs falls.
  - CMD → ADDR: after the 8th rising edge. The command register holds bits 63:56.
  - ADDR → DATA: after the 32nd rising edge. The address register holds bits 55:32.
    - In the same cycle, mem[addr[AW-1:0]] is read into the 32-bit read shift register if the command is non-zero.
    - If the command is 0x00, the read shift register is loaded with 0.
  - DATA → DONE: after the 64th rising edge.
    - On the next clk, if the command is 0x00, the received data word is written to mem[addr[AW-1:0]].
    - frame_done pulses, and frame_cmd and frame_addr update.
  - DONE: all further sck edges are ignored. DONE → IDLE when cs rises.
  - Any state other than IDLE and DONE → IDLE when cs rises. frame_abort pulses, no memory write occurs, and frame_cmd and frame_addr are unchanged.
- MISO in DATA state: on each falling edge, miso is set to rd_shift[31] and rd_shift shifts left by one with 0 fill.
  - The first falling edge after bit 32 presents read bit 31.
  - The falling edge following bit 63 presents read bit 0.
  - In all other states miso is 0.
- Memory: DEPTH×32 flops, all cleared by rst. A read in a frame following a write returns the written value.
- Simultaneous events: cs rising in the same cycle as the 64th rising-edge detect. The rising edge is processed first, so the frame completes. The FSM then goes to IDLE, not DONE, with no abort.

## Timing
- Reset values:
  - miso=0, frame_done=0, frame_abort=0, frame_cmd=0, frame_addr=0.
  - FSM=IDLE, counters=0, memory all 0.
- rst asserted mid-frame: the next cycle is the reset state, and any pending write is discarded.
- Sync latency: 2 clk from a pin change to the synchronised value, plus 1 clk for edge detection.
- SCK constraints: high and low phases must each be at least 4 clk. cs setup to the first sck falling edge, and cs hold after the last rising edge, must each be at least 4 clk.
- Read fetch: the memory read completes 1 clk after the 32nd rising-edge detect, before the next falling-edge detect.
- Write commit: 1 clk after the 64th rising-edge detect. frame_done pulses in that same cycle.
- miso changes 1 clk after a falling-edge detect, giving at least a half sck period of setup before the master samples on the next rising edge.

## Test plan
- Write then read:
  - Frame {00, 000003, DEADBEEF}, then frame {01, 000003, 00000000}.
  - Required: miso returns DEADBEEF MSB first in bits 32..63. frame_done pulses once per frame. frame_cmd=01 and frame_addr=000003 after the second frame.
- Address wrap with DEPTH=16:
  - Write {00, 000013, 12345678}, then read address 000003.
  - Required: read returns 12345678.
- Abort:
  - Write frame to address 5 with data A5A5A5A5, with cs raised after 40 bits.
  - Required: frame_abort pulses and no frame_done. A subsequent read of address 5 returns 00000000.
- Write frame miso quiet:
  - Full write frame {00, 000000, FFFFFFFF}.
  - Required: miso stays 0 for all 64 bits.
- Extra clocks:
  - Read frame followed by 8 extra sck cycles before cs rises.
  - Required: exactly one frame_done, miso 0 after bit 63, no state change until cs rises.
- Reset mid-frame:
  - Pulse rst after 50 bits of a write to address 2.
  - Required: all outputs at reset values. After cs cycles, a read of address 2 returns 00000000 and the next frame decodes correctly.
